aes128_key_expand: RTL and testbench
====================================

// Module: aes128_key_expand
// PURPOSE
//  Iterative AES-128 key schedule (FIPS-197 5.2). Produces round keys 0..NR, one per handshake.
//  Sits directly upstream of the iterative cipher round; replaces its single static key input.
//  Key is captured on start. Keys are streamed over a valid/ready interface.
// PARAMETERS
//  N    128  key / round-key width in bits (fixed at 128; other values unsupported)
//  NR   10   number of rounds; NR+1 keys are emitted (RW = $clog2(NR+1) = 4)
// PORTS
//  clk       in   1    rising-edge clock
//  rst_n     in   1    asynchronous active-low reset
//  start     in   1    request a schedule; accepted only in IDLE
//  key_in    in   N    cipher key; sampled in the cycle start is accepted
//  busy      out  1    high from the cycle after start is accepted until done
//  rk_valid  out  1    rk_out/rk_round are valid
//  rk_ready  in   1    consumer accepts the current key when rk_valid && rk_ready
//  rk_out    out  N    current round key
//  rk_round  out  RW   index of rk_out, 0..NR
//  done      out  1    one-cycle pulse the cycle after key NR is accepted
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, rk_valid=0, rk_out=0, rk_round=0, done=0, rcon=8'h01.
//  FSM is IDLE -> EMIT -> (ADVANCE -> EMIT)* -> FIN -> IDLE.
//   IDLE: on start, load rk_out=key_in, rk_round=0, rcon=01, and go to EMIT. This gives 1-cycle latency to the first rk_valid.
//   EMIT: rk_valid=1. rk_out and rk_round are held stable until accepted. A stall of any length is legal.
//         On accept with rk_round<NR, go to ADVANCE. On accept with rk_round==NR, go to FIN.
//   ADVANCE: rk_valid=0. Register the next key, rk_round+=1, rcon=xtime(rcon), then go to EMIT.
//            Each subsequent key is valid 2 cycles after the previous key's accept.
//   FIN: done=1 for exactly one cycle, busy=0 next cycle, then go to IDLE.
//  Next-key math, with w0..w3 = rk_out[127:96]..[31:0]:
//   t  = SubWord(RotWord(w3)) ^ {rcon,24'h0}
//   w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'
//  rcon sequence for rounds 1..10 is 01,02,04,08,10,20,40,80,1b,36. It is an 8-bit xtime with 0x1b reduction.
//  start outside IDLE (EMIT/ADVANCE/FIN) is ignored. key_in changes after capture have no effect.
//  rk_ready while rk_valid=0 has no effect.
//  rst_n low mid-schedule: immediate return to reset values; no done pulse. Partial schedule is discarded.
//  Back-to-back: start may be accepted in the IDLE cycle directly after FIN.
// CONFIGURATION
//  AES_KEY_STORE_EN defined:
//   - adds port rd_idx (in RW) and port rd_key (out N).
//   - each key is written into an internal (NR+1)xN array at index rk_round when it is accepted.
//   - rd_key = store[rd_idx] combinationally; rd_idx>NR returns 0.
//   - the array is cleared on reset and is not cleared on start; old entries persist until overwritten.
//  AES_KEY_STORE_EN undefined: no array, no rd_* ports; streaming only.
// STRUCTURE
//  Package aes_pkg:
//   - state enum kexp_state_t {IDLE, EMIT, ADVANCE, FIN}
//   - localparams AES_NR=10, AES_RCON0=8'h01, AES_RCON_POLY=8'h1b
//   - functions xtime(), rot_word()
//   - the 256-entry sbox function, shared with the cipher round
//  Sub-module aes_sbox_word: 32-bit SubWord, built from 4 parallel sbox lookups. One instance, on RotWord(w3).
// TESTING
//  1 FIPS-197 A.1: key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1.
//    Expect rk0=key, rk1=a0fafe1788542cb123a339392a6c7605, rk10=d014f9a8c9ee2589e13f0cc8b6630ca6, then done.
//  2 Backpressure: hold rk_ready=0 for 5 cycles at round 3.
//    Expect rk_out and rk_round=3 stable and rk_valid high throughout; schedule resumes correctly.
//  3 start pulsed at round 5 with a different key_in: ignored; remaining keys match the original key's schedule.
//  4 Reset at round 7: all outputs return to 0 asynchronously.
//    A new start with key 000..0 gives rk1=62636363626363636263636362636363.
//  5 Back-to-back: start in the IDLE cycle right after done.
//    Expect second schedule correct; rcon restarts at 01 (rk1 matches test 1).
//  6 AES_KEY_STORE_EN: after test 1, rd_idx=10 -> d014...0ca6, rd_idx=0 -> key, rd_idx=15 -> 0.

Source files
------------

// File: rtl/aes128_key_expand_pkg.sv
// rtl/aes128_key_expand_pkg.sv - AES-128 key schedule shared types, constants and byte/word helpers.
// The sbox() function is also used by the cipher round.
package aes_pkg;

    localparam int AES_N  = 128;
    localparam int AES_NR = 10;
    localparam int AES_RW = $clog2(AES_NR + 1);

    localparam logic [7:0] AES_RCON0     = 8'h01;
    localparam logic [7:0] AES_RCON_POLY = 8'h1b;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        ADVANCE,
        FIN
    } kexp_state_t;

    // Entry 0 sits in the most significant byte, so byte b lives at bit offset 8*(255-b).
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] base;
        base = {~b, 3'b000};
        return SBOX_TABLE[base +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_RCON_POLY : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes128_key_expand_if.sv
// rtl/aes128_key_expand_if.sv - start/key request and round-key stream bundle for the key schedule.
// AES_KEY_STORE_EN adds the rd_idx/rd_key random-access read port.
interface aes128_key_expand_if;
    import aes_pkg::*;

    logic              start;
    logic [AES_N-1:0]  key_in;
    logic              busy;
    logic              rk_valid;
    logic              rk_ready;
    logic [AES_N-1:0]  rk_out;
    logic [AES_RW-1:0] rk_round;
    logic              done;
`ifdef AES_KEY_STORE_EN
    logic [AES_RW-1:0] rd_idx;
    logic [AES_N-1:0]  rd_key;

    modport master (
        output start, key_in, rk_ready, rd_idx,
        input  busy, rk_valid, rk_out, rk_round, done, rd_key
    );
    modport slave (
        input  start, key_in, rk_ready, rd_idx,
        output busy, rk_valid, rk_out, rk_round, done, rd_key
    );
`else
    modport master (
        output start, key_in, rk_ready,
        input  busy, rk_valid, rk_out, rk_round, done
    );
    modport slave (
        input  start, key_in, rk_ready,
        output busy, rk_valid, rk_out, rk_round, done
    );
`endif

endinterface

// File: rtl/aes128_key_expand_sbox_word.sv
// rtl/aes128_key_expand_sbox_word.sv - 32-bit SubWord built from four parallel sbox lookups.
module aes_sbox_word
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign word_o[8*i +: 8] = sbox(word_i[8*i +: 8]);
    end

endmodule

// File: rtl/aes128_key_expand.sv
// rtl/aes128_key_expand.sv - iterative AES-128 key schedule streaming round keys 0..NR.
// AES_KEY_STORE_EN keeps every accepted key in a readable (NR+1)-entry array.
module aes128_key_expand
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    aes128_key_expand_if.slave kx
);

    localparam logic [AES_RW-1:0] LAST_ROUND = AES_RW'(AES_NR);

    kexp_state_t       state_q;
    logic [AES_N-1:0]  rk_out_q;
    logic [AES_RW-1:0] rk_round_q;
    logic [7:0]        rcon_q;
    logic              busy_q;
    logic              rk_valid_q;
    logic              done_q;

    logic [31:0]       w0, w1, w2, w3;
    logic [31:0]       rot_w, sub_w, t;
    logic [31:0]       n0, n1, n2, n3;
    logic [AES_N-1:0]  next_key_d;
    logic              accept;

    assign {w0, w1, w2, w3} = rk_out_q;
    assign rot_w = rot_word(w3);

    aes_sbox_word u_sbox (
        .word_i (rot_w),
        .word_o (sub_w)
    );

    assign t  = sub_w ^ {rcon_q, 24'h000000};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign next_key_d = {n0, n1, n2, n3};

    // rk_valid_q is only ever high in EMIT, so this is the stream handshake.
    assign accept = rk_valid_q && kx.rk_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rk_out_q   <= '0;
            rk_round_q <= '0;
            rcon_q     <= AES_RCON0;
            busy_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (kx.start) begin
                        rk_out_q   <= kx.key_in;
                        rk_round_q <= '0;
                        rcon_q     <= AES_RCON0;
                        busy_q     <= 1'b1;
                        rk_valid_q <= 1'b1;
                        state_q    <= EMIT;
                    end
                end
                EMIT: begin
                    if (accept) begin
                        rk_valid_q <= 1'b0;
                        if (rk_round_q == LAST_ROUND) begin
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            state_q <= ADVANCE;
                        end
                    end
                end
                ADVANCE: begin
                    rk_out_q   <= next_key_d;
                    rk_round_q <= rk_round_q + AES_RW'(1);
                    rcon_q     <= xtime(rcon_q);
                    rk_valid_q <= 1'b1;
                    state_q    <= EMIT;
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign kx.busy     = busy_q;
    assign kx.rk_valid = rk_valid_q;
    assign kx.rk_out   = rk_out_q;
    assign kx.rk_round = rk_round_q;
    assign kx.done     = done_q;

`ifdef AES_KEY_STORE_EN
    logic [AES_N-1:0] store_q [AES_NR+1];

    // Cleared only by reset; a new start leaves older entries readable until overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= AES_NR; i++) begin
                store_q[i] <= '0;
            end
        end else if (accept) begin
            store_q[rk_round_q] <= rk_out_q;
        end
    end

    assign kx.rd_key = (kx.rd_idx <= LAST_ROUND) ? store_q[kx.rd_idx] : '0;
`endif

endmodule

// File: tb/tb_aes128_key_expand.sv
// tb/tb_aes128_key_expand.sv - self-checking bench for aes128_key_expand against a FIPS-197 key-schedule model.
module tb_aes128_key_expand;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] sbox_ref [256];

    always #5 clk = ~clk;

    aes128_key_expand_if bus();

    aes128_key_expand dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kx    (bus)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
    task automatic build_sbox;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_key(input logic [127:0] key, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus.rk_valid === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_start(input logic [127:0] key);
        bus.start  = 1'b1;
        bus.key_in = key;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.key_in = rand_key();
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.key_in   = '0;
        bus.rk_ready = 1'b0;
`ifdef AES_KEY_STORE_EN
        bus.rd_idx   = '0;
`endif
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.rk_valid, bus.done, bus.rk_round, bus.rk_out} !== '0)
            begin errors++; $display("FAIL reset_outputs got=%h exp=0", {bus.busy, bus.rk_valid, bus.done, bus.rk_round, bus.rk_out}); end
        rst_n        = 1'b1;
        bus.rk_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.rk_valid, bus.done} !== 3'b000)
            begin errors++; $display("FAIL idle_ready_no_effect got=%b exp=000", {bus.busy, bus.rk_valid, bus.done}); end
    endtask

    task automatic test_fips;
        logic [127:0] rk1, rk10;
        bus.rk_ready = 1'b1;
        do_start(FIPS_KEY);
        checks++;
        if (bus.rk_valid !== 1'b1 || bus.busy !== 1'b1)
            begin errors++; $display("FAIL first_latency valid=%b busy=%b exp=1,1", bus.rk_valid, bus.busy); end
        for (int r = 0; r <= 10; r++) begin
            if (r > 0) begin
                checks++;
                if (bus.rk_valid !== 1'b0)
                    begin errors++; $display("FAIL advance_gap r=%0d valid=%b exp=0", r, bus.rk_valid); end
                @(negedge clk);
            end
            checks++;
            if (bus.rk_valid !== 1'b1 || bus.rk_round !== 4'(r) || bus.rk_out !== ref_key(FIPS_KEY, r))
                begin errors++; $display("FAIL fips_key r=%0d got=%h/%0d exp=%h/%0d", r, bus.rk_out, bus.rk_round, ref_key(FIPS_KEY, r), r); end
            if (r == 1)  rk1  = bus.rk_out;
            if (r == 10) rk10 = bus.rk_out;
            @(negedge clk);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.rk_valid !== 1'b0)
            begin errors++; $display("FAIL done_pulse done=%b valid=%b exp=1,0", bus.done, bus.rk_valid); end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0)
            begin errors++; $display("FAIL done_end done=%b busy=%b exp=0,0", bus.done, bus.busy); end
        checks++;
        if (rk1 !== FIPS_RK1 || rk10 !== FIPS_RK10)
            begin errors++; $display("FAIL fips_vectors rk1=%h rk10=%h exp=%h %h", rk1, rk10, FIPS_RK1, FIPS_RK10); end
    endtask

`ifdef AES_KEY_STORE_EN
    task automatic test_key_store;
        logic [127:0] exp;
        for (int i = 0; i < 16; i++) begin
            bus.rd_idx = 4'(i);
            #1;
            exp = (i <= 10) ? ref_key(FIPS_KEY, i) : 128'h0;
            checks++;
            if (bus.rd_key !== exp)
                begin errors++; $display("FAIL store_read idx=%0d got=%h exp=%h", i, bus.rd_key, exp); end
        end
        bus.rd_idx = 4'd10;
        #1;
        checks++;
        if (bus.rd_key !== FIPS_RK10)
            begin errors++; $display("FAIL store_rk10 got=%h exp=%h", bus.rd_key, FIPS_RK10); end
        @(negedge clk);
    endtask
`endif

    task automatic test_backpressure;
        logic [127:0] key;
        bit ok;
        key = rand_key();
        bus.rk_ready = 1'b1;
        do_start(key);
        for (int r = 0; r <= 10; r++) begin
            wait_valid(ok);
            if (r == 3) begin
                bus.rk_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    checks++;
                    if (bus.rk_valid !== 1'b1 || bus.rk_round !== 4'd3 || bus.rk_out !== ref_key(key, 3))
                        begin errors++; $display("FAIL stall_hold s=%0d got=%h/%0d v=%b exp=%h/3 v=1", s, bus.rk_out, bus.rk_round, bus.rk_valid, ref_key(key, 3)); end
                end
                bus.rk_ready = 1'b1;
            end
            checks++;
            if (!ok || bus.rk_round !== 4'(r) || bus.rk_out !== ref_key(key, r))
                begin errors++; $display("FAIL bp_key r=%0d got=%h/%0d exp=%h/%0d", r, bus.rk_out, bus.rk_round, ref_key(key, r), r); end
            @(negedge clk);
        end
        checks++;
        if (bus.done !== 1'b1)
            begin errors++; $display("FAIL bp_done got=%b exp=1", bus.done); end
        @(negedge clk);
    endtask

    task automatic test_start_ignored;
        logic [127:0] key;
        bit ok;
        key = rand_key();
        bus.rk_ready = 1'b1;
        do_start(key);
        for (int r = 0; r <= 10; r++) begin
            wait_valid(ok);
            if (r == 5) begin
                bus.start  = 1'b1;
                bus.key_in = ~key;
            end
            if (r == 6) bus.start = 1'b0;
            checks++;
            if (!ok || bus.rk_round !== 4'(r) || bus.rk_out !== ref_key(key, r))
                begin errors++; $display("FAIL ign_key r=%0d got=%h/%0d exp=%h/%0d", r, bus.rk_out, bus.rk_round, ref_key(key, r), r); end
            @(negedge clk);
        end
        checks++;
        if (bus.done !== 1'b1)
            begin errors++; $display("FAIL ign_done got=%b exp=1", bus.done); end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.rk_valid !== 1'b0)
            begin errors++; $display("FAIL ign_idle busy=%b valid=%b exp=0,0", bus.busy, bus.rk_valid); end
    endtask

    task automatic test_reset_mid;
        logic [127:0] key;
        bit ok;
        key = rand_key();
        bus.rk_ready = 1'b1;
        do_start(key);
        for (int r = 0; r < 7; r++) begin
            wait_valid(ok);
            @(negedge clk);
        end
        wait_valid(ok);
        checks++;
        if (!ok || bus.rk_round !== 4'd7)
            begin errors++; $display("FAIL pre_reset_round got=%0d exp=7", bus.rk_round); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.rk_valid, bus.done, bus.rk_round, bus.rk_out} !== '0)
            begin errors++; $display("FAIL async_reset got=%h exp=0", {bus.busy, bus.rk_valid, bus.done, bus.rk_round, bus.rk_out}); end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.rk_valid !== 1'b0)
                begin errors++; $display("FAIL reset_no_done done=%b valid=%b exp=0,0", bus.done, bus.rk_valid); end
        end
        rst_n = 1'b1;
        do_start(128'h0);
        for (int r = 0; r <= 10; r++) begin
            wait_valid(ok);
            checks++;
            if (!ok || bus.rk_round !== 4'(r) || bus.rk_out !== ref_key(128'h0, r))
                begin errors++; $display("FAIL zero_key r=%0d got=%h/%0d exp=%h/%0d", r, bus.rk_out, bus.rk_round, ref_key(128'h0, r), r); end
            if (r == 1) begin
                checks++;
                if (bus.rk_out !== ZERO_RK1)
                    begin errors++; $display("FAIL zero_rk1 got=%h exp=%h", bus.rk_out, ZERO_RK1); end
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [127:0] key;
        bit ok;
        key = rand_key();
        bus.rk_ready = 1'b1;
        do_start(key);
        for (int r = 0; r <= 10; r++) begin
            wait_valid(ok);
            checks++;
            if (!ok || bus.rk_out !== ref_key(key, r))
                begin errors++; $display("FAIL b2b_first r=%0d got=%h exp=%h", r, bus.rk_out, ref_key(key, r)); end
            @(negedge clk);
        end
        checks++;
        if (bus.done !== 1'b1)
            begin errors++; $display("FAIL b2b_done got=%b exp=1", bus.done); end
        @(negedge clk);
        do_start(FIPS_KEY);
        for (int r = 0; r <= 10; r++) begin
            wait_valid(ok);
            checks++;
            if (!ok || bus.rk_round !== 4'(r) || bus.rk_out !== ref_key(FIPS_KEY, r))
                begin errors++; $display("FAIL b2b_second r=%0d got=%h/%0d exp=%h/%0d", r, bus.rk_out, bus.rk_round, ref_key(FIPS_KEY, r), r); end
            if (r == 1) begin
                checks++;
                if (bus.rk_out !== FIPS_RK1)
                    begin errors++; $display("FAIL b2b_rk1 got=%h exp=%h", bus.rk_out, FIPS_RK1); end
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [127:0] key;
        bit ok;
        for (int k = 0; k < 4; k++) begin
            key = rand_key();
            bus.rk_ready = 1'($urandom_range(0, 1));
            do_start(key);
            for (int r = 0; r <= 10; r++) begin
                wait_valid(ok);
                bus.rk_ready = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                checks++;
                if (!ok || bus.rk_valid !== 1'b1 || bus.rk_round !== 4'(r) || bus.rk_out !== ref_key(key, r))
                    begin errors++; $display("FAIL rand_key k=%0d r=%0d got=%h/%0d exp=%h/%0d", k, r, bus.rk_out, bus.rk_round, ref_key(key, r), r); end
                bus.rk_ready = 1'b1;
                @(negedge clk);
                bus.rk_ready = 1'($urandom_range(0, 1));
            end
            checks++;
            if (bus.done !== 1'b1)
                begin errors++; $display("FAIL rand_done k=%0d got=%b exp=1", k, bus.done); end
            @(negedge clk);
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips();
`ifdef AES_KEY_STORE_EN
        test_key_store();
`endif
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
